// File: rtl/adder_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_bist_pkg
//  Description : Shared types and constants for the adder BIST engine:
//                run-state encoding, LFSR feedback polynomial, the fixed
//                corner-vector table and the "no failure seen" marker.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    // (x^32 -> bit 31, x^22 -> bit 21, x^2 -> bit 1, x^1 -> bit 0).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [15:0] NO_FAIL = 16'hFFFF;

    localparam int NUM_CORNERS = 4;

    // Corner vectors: zero, carry ripple through all bits, max+max, MSB carry.
    localparam logic [31:0] CORNER_A [NUM_CORNERS] = '{
        32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000
    };
    localparam logic [31:0] CORNER_B [NUM_CORNERS] = '{
        32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000
    };

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_bist_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr32
//  Description : 32-bit Galois LFSR with synchronous seed load and advance.
//  Ports       : clk       - clock
//                rst       - asynchronous active-high reset (state <= SEED)
//                i_load    - load i_seed (has priority over advance)
//                i_advance - step the LFSR once
//                i_seed    - value loaded on i_load
//                o_q       - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr32
    import adder_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_seed,
    output logic [31:0] o_q
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (i_load) begin
            state_d = i_seed;
        end else if (i_advance) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_q = state_q;

endmodule
`default_nettype wire

// File: rtl/adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : adder_bist
//  Description : Stimulus/response engine for a registered adder harness.
//                Issues NUM_VECTORS operand pairs (4 corners, then LFSR
//                vectors), tracks the expected sum through a LATENCY-deep
//                pipe and compares it with the returned Result.
//  Ports       : clk        - clock
//                RST        - asynchronous active-high reset
//                start      - run request, honoured in IDLE or DONE only
//                A, B, Sel  - registered operands / path select to harness
//                Result     - harness result
//                busy       - run in progress (RUN or DRAIN)
//                done       - run finished, held until next start
//                pass       - valid with done: no mismatches this run
//                err_count  - saturating mismatch count
//                first_fail - index of first mismatching vector or 16'hFFFF
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          RWIDTH      = 40,
    parameter int          LATENCY     = 2,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'h1ACE_B00C,
    parameter logic [31:0] SEED_B      = 32'hC0FF_EE11
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic              Sel,
    input  logic [RWIDTH-1:0] Result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [15:0]       first_fail
);

    state_t             state_q, state_d;
    logic [15:0]        idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [15:0]        err_q, err_d;
    logic [15:0]        ff_q, ff_d;

    // Expected-result pipe, stage 0 loaded on the same edge as A/B.
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [RWIDTH-1:0]  pe_q [LATENCY];
    logic [RWIDTH-1:0]  pe_d [LATENCY];
    logic [15:0]        pi_q [LATENCY];
    logic [15:0]        pi_d [LATENCY];

    logic               w_launch;
    logic               w_issue;
    logic               w_to_done;
    logic               w_is_corner;
    logic               w_mismatch;
    logic [15:0]        w_cur_idx;
    logic [WIDTH-1:0]   w_vec_a;
    logic [WIDTH-1:0]   w_vec_b;
    logic [WIDTH:0]     w_sum;
    logic [RWIDTH-1:0]  w_exp;
    logic [31:0]        w_lfsr_a;
    logic [31:0]        w_lfsr_b;

    // Vector 0 goes out on the very edge that accepts start, so the first
    // RUN cycle already issues vector 1.
    always_comb begin
        w_launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
        w_issue     = w_launch || (state_q == RUN);
        w_to_done   = (state_q == DRAIN) && (pv_q == '0);
        w_cur_idx   = w_launch ? 16'd0 : idx_q;
        w_is_corner = (w_cur_idx < 16'(NUM_CORNERS));
        w_vec_a     = w_is_corner ? CORNER_A[w_cur_idx[1:0]] : w_lfsr_a;
        w_vec_b     = w_is_corner ? CORNER_B[w_cur_idx[1:0]] : w_lfsr_b;
        w_sum       = {1'b0, w_vec_a} + {1'b0, w_vec_b};
        w_exp       = {{(RWIDTH-WIDTH-1){1'b0}}, w_sum};
        w_mismatch  = pv_q[LATENCY-1] && (Result != pe_q[LATENCY-1]);
    end

    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk       (clk),
        .rst       (RST),
        .i_load    (w_launch),
        .i_advance (w_issue && !w_is_corner),
        .i_seed    (SEED_A),
        .o_q       (w_lfsr_a)
    );

    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk       (clk),
        .rst       (RST),
        .i_load    (w_launch),
        .i_advance (w_issue && !w_is_corner),
        .i_seed    (SEED_B),
        .o_q       (w_lfsr_b)
    );

    // Run control and operand registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = 16'd1;
                end
            end
            RUN: begin
                idx_d = idx_q + 16'd1;
                if (idx_q == 16'(NUM_VECTORS-1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_to_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_issue) begin
            a_d   = w_vec_a;
            b_d   = w_vec_b;
            sel_d = w_cur_idx[0];
        end else if (w_to_done) begin
            a_d   = '0;
            b_d   = '0;
            sel_d = 1'b0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // Checker: the final comparison lands at least one edge before the
    // pipe reads empty, so err_q is settled when pass is taken.
    always_comb begin
        err_d  = err_q;
        ff_d   = ff_q;
        pass_d = pass_q;
        if (w_launch) begin
            err_d  = 16'd0;
            ff_d   = NO_FAIL;
            pass_d = 1'b0;
        end else begin
            if (w_mismatch) begin
                if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                if (ff_q == NO_FAIL) begin
                    ff_d = pi_q[LATENCY-1];
                end
            end
            if (w_to_done) begin
                pass_d = (err_q == 16'd0);
            end
        end
    end

    always_comb begin
        pv_d[0] = w_issue;
        pe_d[0] = w_exp;
        pi_d[0] = w_cur_idx;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= 16'd0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'd0;
            ff_q    <= NO_FAIL;
            pv_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pe_q[i] <= '0;
                pi_q[i] <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pv_q    <= pv_d;
            for (int i = 0; i < LATENCY; i++) begin
                pe_q[i] <= pe_d[i];
                pi_q[i] <= pi_d[i];
            end
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign Sel        = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_bist
//  Description : Bench for adder_bist. Wraps the BIST with a behavioural
//                registered adder (one register after the BIST's own operand
//                register, giving a two-cycle loop) and optional faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_bist;

    localparam int N   = 256;
    localparam int LAT = 2;

    logic        clk;
    logic        RST;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sel;
    logic [39:0] Result;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_fail;

    int errors;
    int checks;
    int fault_mode;          // 0 good, 1 carry bit stuck at 0, 2 flip LSB on vector 100

    logic [31:0] va [N];
    logic [31:0] vb [N];

    adder_bist #(
        .WIDTH       (32),
        .RWIDTH      (40),
        .LATENCY     (LAT),
        .NUM_VECTORS (N),
        .SEED_A      (32'h1ACE_B00C),
        .SEED_B      (32'hC0FF_EE11)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .A          (A),
        .B          (B),
        .Sel        (Sel),
        .Result     (Result),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] harness_f(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [39:0] r;
        r = 40'(a) + 40'(b);
        if (fault_mode == 1) r[32] = 1'b0;
        if (fault_mode == 2 && a == va[100] && b == vb[100] && s == 1'b0) r = r ^ 40'd1;
        return r;
    endfunction

    // Reset leaves garbage on Result; it must never be scored.
    always @(posedge clk or posedge RST) begin
        if (RST) Result <= {8'($urandom), $urandom};
        else     Result <= harness_f(A, B, Sel);
    end

    // Reference vector list: 4 corners then successive states of the
    // x^32+x^22+x^2+x+1 Galois register, starting at the seed.
    task automatic build_model();
        logic [31:0] sa, sb, taps;
        taps = 32'h0;
        taps[31] = 1'b1; taps[21] = 1'b1; taps[1] = 1'b1; taps[0] = 1'b1;
        va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;
        sa = 32'h1ACE_B00C;
        sb = 32'hC0FF_EE11;
        for (int k = 4; k < N; k++) begin
            va[k] = sa;
            vb[k] = sb;
            sa = (sa >> 1) ^ (sa[0] ? taps : 32'h0);
            sb = (sb >> 1) ^ (sb[0] ? taps : 32'h0);
        end
    endtask

    // One full run from IDLE/DONE; optional stray start pulses in RUN and DRAIN.
    task automatic do_run(input int fmode, input bit poke, input int exp_err,
                          input logic [15:0] exp_ff);
        int busy_cnt, done_at, p1, p2;
        fault_mode = fmode;
        p1 = $urandom_range(N-2, 2);
        p2 = $urandom_range(N+1, N);
        busy_cnt = 0;
        done_at  = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= N + LAT + 20 && done_at == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_at = c;
            if (c == 1) begin
                checks++;
                if ({busy, done, pass, err_count, first_fail} !== {3'b100, 16'd0, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL run_clear: busy/done/pass/err/ff=%b%b%b %h %h required 100 0000 ffff",
                             busy, done, pass, err_count, first_fail);
                end
            end
            if (c == 2) begin
                checks++;
                if ({A, B, Sel} !== {32'hFFFF_FFFF, 32'h0000_0001, 1'b1}) begin
                    errors++;
                    $display("FAIL corner1: A=%h B=%h Sel=%b required ffffffff 00000001 1", A, B, Sel);
                end
            end
            if (c == 6 && fmode == 1) begin
                checks++;
                if (err_count !== 16'd3 || first_fail !== 16'd1) begin
                    errors++;
                    $display("FAIL carry_corners: err=%0d ff=%0d required 3 1", err_count, first_fail);
                end
            end
            if (c <= N) begin
                checks++;
                if (A !== va[c-1] || B !== vb[c-1] || Sel !== 1'((c-1) % 2)) begin
                    errors++;
                    $display("FAIL vector%0d: A=%h B=%h Sel=%b required %h %h %b",
                             c-1, A, B, Sel, va[c-1], vb[c-1], 1'((c-1) % 2));
                end
            end else if (busy) begin
                checks++;
                if (A !== va[N-1] || B !== vb[N-1] || Sel !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_hold: A=%h B=%h Sel=%b required %h %h 1",
                             A, B, Sel, va[N-1], vb[N-1]);
                end
            end
            if (poke && (c == p1 || c == p2)) start = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (done_at == 0) begin
            errors++;
            $display("FAIL done_timeout: done never rose within %0d cycles", N + LAT + 20);
        end
        checks++;
        if (busy_cnt != N + LAT || done_at != N + LAT + 1) begin
            errors++;
            $display("FAIL run_length: busy=%0d done_at=%0d required %0d %0d",
                     busy_cnt, done_at, N + LAT, N + LAT + 1);
        end
        checks++;
        if (pass !== (exp_err == 0) || err_count !== 16'(exp_err) || first_fail !== exp_ff) begin
            errors++;
            $display("FAIL verdict: pass=%b err=%0d ff=%0d required %b %0d %0d",
                     pass, err_count, first_fail, (exp_err == 0), exp_err, exp_ff);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({done, busy, A, B, Sel} !== {2'b10, 65'd0}) begin
                errors++;
                $display("FAIL done_hold: done=%b busy=%b A=%h B=%h Sel=%b required 1 0 0 0 0",
                         done, busy, A, B, Sel);
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b1;            // must be ignored while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({A, B, Sel, busy, done, pass, err_count, first_fail} !== {69'd0, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_state: A=%h B=%h Sel=%b busy=%b done=%b pass=%b err=%h ff=%h required all 0, ff=ffff",
                     A, B, Sel, busy, done, pass, err_count, first_fail);
        end
        start = 1'b0;
        RST   = 1'b0;
        repeat ($urandom_range(5, 2)) @(negedge clk);
        checks++;
        if ({busy, done, err_count} !== 18'd0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b err=%h required 0 0 0", busy, done, err_count);
        end
    endtask

    task automatic test_good_run();
        do_run(0, 1'b0, 0, 16'hFFFF);
    endtask

    task automatic test_fault_carry();
        int cnt;
        logic [39:0] s;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            s = 40'(va[k]) + 40'(vb[k]);
            if (s[32]) cnt++;
        end
        do_run(1, 1'b0, cnt, 16'd1);
    endtask

    task automatic test_fault_single();
        do_run(2, 1'b0, 1, 16'd100);
    endtask

    task automatic test_back_to_back();
        // Starts straight from DONE of a failing run; stray starts mid-run.
        do_run(0, 1'b1, 0, 16'hFFFF);
    endtask

    task automatic test_mid_run_reset();
        fault_mode = 2;
        @(negedge clk);
        start = 1'b1;
        repeat (50) begin
            @(negedge clk);
            start = 1'b0;
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({A, B, Sel, busy, done, pass, err_count, first_fail} !== {69'd0, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL midrun_reset: A=%h B=%h Sel=%b busy=%b done=%b pass=%b err=%h ff=%h required all 0, ff=ffff",
                     A, B, Sel, busy, done, pass, err_count, first_fail);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        repeat ($urandom_range(4, 1)) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_midrun_reset: busy=%b done=%b required 0 0", busy, done);
        end
        do_run(0, 1'b0, 0, 16'hFFFF);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        fault_mode = 0;
        RST        = 1'b1;
        start      = 1'b0;
        build_model();
        test_reset();
        test_good_run();
        test_fault_carry();
        test_fault_single();
        test_back_to_back();
        test_mid_run_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
